ov7670_pixel_packer: RTL and testbench

Capture front-end for the OV7670 path, in the clk_cam (PCLK) domain. Takes the raw 8-bit RGB565 byte stream plus VSYNC/HREF and delineates frames and rows. Packs two pixels per 32-bit word and emits the words with a line-buffer word address. Emits frame/row framing pulses to the downstream row writer, which fills the ping-pong sdpb_1kx32 line buffers and issues the frame-start/row/frame-end commands across the CDC.

---
 rtl/camera_pipeline_pkg.sv | 37 +++
 rtl/ov7670_input_sync.sv | 53 +++++
 rtl/ov7670_pixel_packer.sv | 197 +++++++++++++++++++
 tb/tb_ov7670_pixel_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : camera_pipeline_pkg
//  Purpose  : Shared types and constants for the OV7670 capture pipeline:
//             capture state encoding, packing geometry, row-writer commands
//             and the byte-to-word packing helper.
//  Revision : 1.0 - initial release
// ============================================================================
package camera_pipeline_pkg;

  // Capture front-end state encoding
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VSYNC = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_ACTIVE     = 2'd3
  } cam_state_e;

  // Packing geometry
  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXELS_PER_WORD = 2;
  localparam int BYTES_PER_WORD  = BYTES_PER_PIXEL * PIXELS_PER_WORD;

  // Command codes understood by the row writer across the CDC
  localparam logic [1:0] CMD_FRAME_START = 2'd1;
  localparam logic [1:0] CMD_ROW         = 2'd2;
  localparam logic [1:0] CMD_FRAME_END   = 2'd3;

  // Builds a 32-bit word from the first three bytes {b0,b1,b2} and the
  // fourth byte b3: even pixel {b0,b1} in [15:0], odd pixel {b2,b3} in [31:16].
  function automatic logic [31:0] pack_word(input logic [23:0] i_first3,
                                            input logic [7:0]  i_last);
    return {i_first3[7:0], i_last, i_first3[23:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_input_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ov7670_input_sync
//  Purpose  : Registers the raw camera pins once and detects VSYNC rise/fall
//             and HREF fall on the registered copies.
//  Revision : 1.0 - initial release
// ============================================================================
module ov7670_input_sync (
  input  logic       clk_cam,
  input  logic       reset_n,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_data,
  output logic       o_vsync_rise,
  output logic       o_vsync_fall,
  output logic       o_href_fall
);

  logic       r_vsync;
  logic       r_href;
  logic [7:0] r_data;
  logic       r_vsync_d;
  logic       r_href_d;

  // Input register stage plus one-cycle history for edge detection
  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_data    <= 8'd0;
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync   <= i_vsync;
      r_href    <= i_href;
      r_data    <= i_data;
      r_vsync_d <= r_vsync;
      r_href_d  <= r_href;
    end
  end

  assign o_vsync      = r_vsync;
  assign o_href       = r_href;
  assign o_data       = r_data;
  assign o_vsync_rise = r_vsync & ~r_vsync_d;
  assign o_vsync_fall = ~r_vsync & r_vsync_d;
  assign o_href_fall  = ~r_href & r_href_d;

endmodule
`default_nettype wire

// File: rtl/ov7670_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ov7670_pixel_packer
//  Purpose  : OV7670 capture front-end. Delineates frames and rows from
//             VSYNC/HREF, packs two RGB565 pixels per 32-bit word with a
//             line-buffer word address, and emits framing/error pulses to
//             the downstream row writer.
//  Revision : 1.0 - initial release
// ============================================================================
module ov7670_pixel_packer
  import camera_pipeline_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk_cam,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  cam_data,
  output logic [31:0] word_data,
  output logic [9:0]  word_addr,
  output logic        word_valid,
  output logic        frame_start,
  output logic        row_done,
  output logic        frame_end,
  output logic        row_error,
  output logic        frame_error,
  output logic [10:0] row_count
);

  localparam logic [11:0] c_ROW_BYTES    = 12'(FRAME_WIDTH * BYTES_PER_PIXEL);
  localparam logic [10:0] c_FRAME_HEIGHT = 11'(FRAME_HEIGHT);
  localparam logic [10:0] c_BYTE_MAX     = 11'h7FF;

  // Registered pin copies and edge strobes
  logic       w_vsync;
  logic       w_href;
  logic [7:0] w_data;
  logic       w_vsync_rise;
  logic       w_vsync_fall;
  logic       w_href_fall;

  ov7670_input_sync u_input_sync (
    .clk_cam      (clk_cam),
    .reset_n      (reset_n),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_data       (cam_data),
    .o_vsync      (w_vsync),
    .o_href       (w_href),
    .o_data       (w_data),
    .o_vsync_rise (w_vsync_rise),
    .o_vsync_fall (w_vsync_fall),
    .o_href_fall  (w_href_fall)
  );

  cam_state_e  r_state;
  logic [10:0] r_byte_cnt;
  logic [23:0] r_shift;
  logic [10:0] r_row_count;
  logic        r_excess;
  logic [31:0] r_word_data;
  logic [9:0]  r_word_addr;
  logic        r_word_valid;
  logic        r_frame_start;
  logic        r_row_done;
  logic        r_frame_end;
  logic        r_row_error;
  logic        r_frame_error;

  logic        w_row_full;
  logic        w_in_window;
  logic        w_emit;
  logic        w_row_good;
  logic [10:0] w_rows_final;
  logic        w_excess_final;

  // Once FRAME_HEIGHT rows are in, further rows are excess and produce nothing
  assign w_row_full     = (r_row_count >= c_FRAME_HEIGHT);
  // Bytes beyond one full row never form a word
  assign w_in_window    = ({1'b0, r_byte_cnt} < c_ROW_BYTES);
  // A word completes on byte phase 3
  assign w_emit         = w_href && !w_row_full && w_in_window &&
                          (r_byte_cnt[1:0] == 2'd3);
  assign w_row_good     = w_href_fall && !w_row_full &&
                          ({1'b0, r_byte_cnt} == c_ROW_BYTES);
  // Row totals as they stand once this cycle's row end (if any) is counted
  assign w_rows_final   = r_row_count + {10'd0, w_row_good};
  assign w_excess_final = r_excess | (w_href & w_row_full);

  // Frame/row sequencing, byte packing and single-cycle output strobes
  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_byte_cnt    <= 11'd0;
      r_shift       <= 24'd0;
      r_row_count   <= 11'd0;
      r_excess      <= 1'b0;
      r_word_data   <= 32'd0;
      r_word_addr   <= 10'd0;
      r_word_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_row_done    <= 1'b0;
      r_frame_end   <= 1'b0;
      r_row_error   <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_word_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_row_done    <= 1'b0;
      r_frame_end   <= 1'b0;
      r_row_error   <= 1'b0;
      r_frame_error <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_WAIT_VSYNC;
          end
        end

        // Hold off until blanking is seen so capture never starts mid-frame
        ST_WAIT_VSYNC: begin
          if (w_vsync) begin
            r_state <= ST_WAIT_FRAME;
          end
        end

        ST_WAIT_FRAME: begin
          if (w_vsync_fall) begin
            r_frame_start <= 1'b1;
            r_row_count   <= 11'd0;
            r_byte_cnt    <= 11'd0;
            r_excess      <= 1'b0;
            r_state       <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (w_href) begin
            // Saturate so an overlong row can never wrap back into range
            if (r_byte_cnt != c_BYTE_MAX) begin
              r_byte_cnt <= r_byte_cnt + 11'd1;
            end
            r_shift <= {r_shift[15:0], w_data};
            if (w_row_full) begin
              r_excess <= 1'b1;
            end
            if (w_emit) begin
              r_word_valid <= 1'b1;
              r_word_data  <= pack_word(r_shift, w_data);
              r_word_addr  <= {1'b0, r_byte_cnt[10:2]};
            end
          end

          // Row end: only an exact-length row within the frame counts
          if (w_href_fall) begin
            r_byte_cnt <= 11'd0;
            if (w_row_good) begin
              r_row_done  <= 1'b1;
              r_row_count <= r_row_count + 11'd1;
            end else begin
              r_row_error <= 1'b1;
            end
          end

          // Frame end; a row still open at this point is truncated
          if (w_vsync_rise) begin
            r_frame_end   <= 1'b1;
            r_frame_error <= (w_rows_final != c_FRAME_HEIGHT) || w_excess_final;
            if (w_href) begin
              r_row_error <= 1'b1;
            end
            r_byte_cnt <= 11'd0;
            r_state    <= enable ? ST_WAIT_FRAME : ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign word_data   = r_word_data;
  assign word_addr   = r_word_addr;
  assign word_valid  = r_word_valid;
  assign frame_start = r_frame_start;
  assign row_done    = r_row_done;
  assign frame_end   = r_frame_end;
  assign row_error   = r_row_error;
  assign frame_error = r_frame_error;
  assign row_count   = r_row_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ov7670_pixel_packer
//  Purpose  : Self-checking bench for ov7670_pixel_packer using a reduced
//             frame geometry, randomized pixel bytes and a frame-level
//             reference model of words, row and frame events.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_pixel_packer;

  localparam int TB_W = 8;
  localparam int TB_H = 4;
  localparam int ROWB = 2 * TB_W;

  logic        clk_cam = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        vsync;
  logic        href;
  logic [7:0]  cam_data;
  logic [31:0] word_data;
  logic [9:0]  word_addr;
  logic        word_valid;
  logic        frame_start;
  logic        row_done;
  logic        frame_end;
  logic        row_error;
  logic        frame_error;
  logic [10:0] row_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Monitor history (only ever appended by the monitor)
  logic [31:0] mw_data[$];
  int          mw_addr[$];
  int          mw_cyc[$];
  int          m_rd_cyc[$];
  int          n_rerr = 0;
  int          n_fs   = 0;
  int          n_fe   = 0;
  int          n_ferr = 0;

  int row_lens[$];

  ov7670_pixel_packer #(.FRAME_WIDTH(TB_W), .FRAME_HEIGHT(TB_H)) dut (
    .clk_cam     (clk_cam),
    .reset_n     (reset_n),
    .enable      (enable),
    .vsync       (vsync),
    .href        (href),
    .cam_data    (cam_data),
    .word_data   (word_data),
    .word_addr   (word_addr),
    .word_valid  (word_valid),
    .frame_start (frame_start),
    .row_done    (row_done),
    .frame_end   (frame_end),
    .row_error   (row_error),
    .frame_error (frame_error),
    .row_count   (row_count)
  );

  initial forever #5 clk_cam = ~clk_cam;

  always @(posedge clk_cam) cyc <= cyc + 1;

  always @(negedge clk_cam) begin
    if (word_valid) begin
      mw_data.push_back(word_data);
      mw_addr.push_back(int'(word_addr));
      mw_cyc.push_back(cyc);
    end
    if (row_done)    m_rd_cyc.push_back(cyc);
    if (row_error)   n_rerr <= n_rerr + 1;
    if (frame_start) n_fs   <= n_fs + 1;
    if (frame_end)   n_fe   <= n_fe + 1;
    if (frame_error) n_ferr <= n_ferr + 1;
  end

  // Applies one pin cycle; edge_i is the clock edge that samples it
  task automatic drive(input logic h, input logic v, input logic [7:0] d, output int edge_i);
    @(posedge clk_cam);
    #1;
    href     = h;
    vsync    = v;
    cam_data = d;
    edge_i   = cyc + 1;
  endtask

  // One frame of stimulus from row_lens, with the expected outcome derived
  // from the byte stream and compared against everything the monitor saw.
  task automatic run_frame(input string name, input bit expect_cap, input int en_row,
                           input bit en_val, input bit trunc_last, input bit col_mode);
    int          base_w, base_rd, base_re, base_fs, base_fe, base_ferr;
    logic [10:0] rc0;
    logic [31:0] xw_data[$];
    int          xw_addr[$];
    int          xw_cyc[$];
    int          xrd_cyc[$];
    logic [7:0]  b[$];
    int          e[$];
    int          x_rerr, g, n, lim, ed, nw, nrd, x_fs, x_ferr;
    bit          excess, last;
    logic [7:0]  d;

    base_w = mw_data.size(); base_rd = m_rd_cyc.size();
    base_re = n_rerr; base_fs = n_fs; base_fe = n_fe; base_ferr = n_ferr;
    rc0 = row_count;
    x_rerr = 0; g = 0; excess = 1'b0;

    repeat (6) drive(1'b0, 1'b1, 8'h00, ed);
    repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
    for (int r = 0; r < row_lens.size(); r++) begin
      b.delete(); e.delete();
      if (r == en_row) enable = en_val;
      for (int i = 0; i < row_lens[r]; i++) begin
        if (col_mode) d = (i % 2 == 0) ? 8'((i / 2) >> 8) : 8'(i / 2);
        else          d = 8'($urandom);
        drive(1'b1, 1'b0, d, ed);
        b.push_back(d); e.push_back(ed);
      end
      last = (r == row_lens.size() - 1);
      if (trunc_last && last) begin
        d = 8'($urandom);
        drive(1'b1, 1'b1, d, ed);
        b.push_back(d); e.push_back(ed);
      end else begin
        repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
      end
      if (expect_cap) begin
        n   = b.size();
        lim = (n < ROWB) ? n : ROWB;
        if (g >= TB_H) begin
          excess = 1'b1;
          x_rerr++;
        end else begin
          for (int w = 0; 4 * w + 3 < lim; w++) begin
            xw_data.push_back({b[4*w+2], b[4*w+3], b[4*w], b[4*w+1]});
            xw_addr.push_back(w);
            xw_cyc.push_back(e[4*w+3] + 1);
          end
          if (n == ROWB && !(trunc_last && last)) begin
            xrd_cyc.push_back(e[n-1] + 2);
            g++;
          end else begin
            x_rerr++;
          end
        end
      end
    end
    repeat (6) drive(1'b0, 1'b1, 8'h00, ed);

    nw = mw_data.size() - base_w;
    checks++;
    if (nw !== xw_data.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d expected %0d", name, nw, xw_data.size());
    end
    for (int i = 0; i < nw && i < xw_data.size(); i++) begin
      checks++;
      if (mw_data[base_w+i] !== xw_data[i] || mw_addr[base_w+i] !== xw_addr[i] ||
          mw_cyc[base_w+i] !== xw_cyc[i]) begin
        errors++;
        $display("FAIL %s word%0d: got data=%h addr=%0d cyc=%0d expected data=%h addr=%0d cyc=%0d",
                 name, i, mw_data[base_w+i], mw_addr[base_w+i], mw_cyc[base_w+i],
                 xw_data[i], xw_addr[i], xw_cyc[i]);
      end
    end
    nrd = m_rd_cyc.size() - base_rd;
    checks++;
    if (nrd !== xrd_cyc.size()) begin
      errors++;
      $display("FAIL %s row_done_count: got %0d expected %0d", name, nrd, xrd_cyc.size());
    end
    for (int i = 0; i < nrd && i < xrd_cyc.size(); i++) begin
      checks++;
      if (m_rd_cyc[base_rd+i] !== xrd_cyc[i]) begin
        errors++;
        $display("FAIL %s row_done%0d_cycle: got %0d expected %0d", name, i,
                 m_rd_cyc[base_rd+i], xrd_cyc[i]);
      end
    end
    x_fs   = expect_cap ? 1 : 0;
    x_ferr = (expect_cap && (g != TB_H || excess)) ? 1 : 0;
    checks++;
    if (n_rerr - base_re !== x_rerr) begin
      errors++;
      $display("FAIL %s row_error_count: got %0d expected %0d", name, n_rerr - base_re, x_rerr);
    end
    checks++;
    if (n_fs - base_fs !== x_fs || n_fe - base_fe !== x_fs) begin
      errors++;
      $display("FAIL %s frame_start/end_count: got %0d/%0d expected %0d/%0d", name,
               n_fs - base_fs, n_fe - base_fe, x_fs, x_fs);
    end
    checks++;
    if (n_ferr - base_ferr !== x_ferr) begin
      errors++;
      $display("FAIL %s frame_error_count: got %0d expected %0d", name, n_ferr - base_ferr, x_ferr);
    end
    checks++;
    if (row_count !== (expect_cap ? 11'(g) : rc0)) begin
      errors++;
      $display("FAIL %s row_count: got %0d expected %0d", name, row_count,
               expect_cap ? 11'(g) : rc0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
    repeat (3) @(posedge clk_cam);
    #1;
    checks++;
    if ({word_data, word_addr, word_valid, frame_start, row_done, frame_end,
         row_error, frame_error, row_count} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h addr=%0d rc=%0d expected all zero",
               word_data, word_addr, row_count);
    end
    #3 reset_n = 1'b1;
    repeat (4) @(posedge clk_cam);
    #1;
    checks++;
    if ({word_valid, frame_start, row_done, frame_end, row_error, frame_error} !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got strobes=%b expected 000000",
               {word_valid, frame_start, row_done, frame_end, row_error, frame_error});
    end
  endtask

  task automatic test_nominal();
    int base;
    enable = 1'b1;
    base = mw_data.size();
    row_lens = '{ROWB, ROWB, ROWB, ROWB};
    run_frame("nominal", 1'b1, -1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (mw_data.size() <= base || mw_data[base] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL nominal_word0: got %h expected 00010000",
               (mw_data.size() > base) ? mw_data[base] : 32'hx);
    end
  endtask

  task automatic test_short_row();
    row_lens = '{ROWB, ROWB - 4, ROWB, ROWB};
    run_frame("short_row", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_odd_row();
    row_lens = '{ROWB, ROWB + 1, ROWB, ROWB};
    run_frame("odd_row", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overlong_row();
    row_lens = '{ROWB, ROWB, ROWB + 8, ROWB};
    run_frame("overlong_row", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_excess_rows();
    row_lens = '{ROWB, ROWB, ROWB, ROWB, ROWB, ROWB};
    run_frame("excess_rows", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_truncated_row();
    row_lens = '{ROWB, ROWB, 6};
    run_frame("truncated_row", 1'b1, -1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      row_lens.delete();
      for (int r = 0; r < TB_H; r++)
        row_lens.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 20)) : ROWB);
      run_frame("back_to_back", 1'b1, -1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_enable();
    row_lens = '{ROWB, ROWB, ROWB, ROWB};
    run_frame("enable_drop", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    run_frame("enable_off", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_frame("enable_raise_midframe", 1'b0, 1, 1'b1, 1'b0, 1'b0);
    run_frame("enable_first_frame", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrow();
    int ed, base_w, base_rd, base_fs, base_re;
    logic [7:0] pre [6];
    pre = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    repeat (6) drive(1'b0, 1'b1, 8'h00, ed);
    repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
    for (int i = 0; i < ROWB; i++) drive(1'b1, 1'b0, 8'($urandom), ed);
    repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, pre[i], ed);
    #2;
    checks++;
    if (word_data !== 32'hA3A4_A1A2 || row_count !== 11'd1) begin
      errors++;
      $display("FAIL pre_reset_state: got data=%h rc=%0d expected data=a3a4a1a2 rc=1",
               word_data, row_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({word_data, word_addr, word_valid, frame_start, row_done, frame_end,
         row_error, frame_error, row_count} !== 59'd0) begin
      errors++;
      $display("FAIL reset_midrow_outputs: got data=%h addr=%0d rc=%0d expected all zero",
               word_data, word_addr, row_count);
    end
    #3 reset_n = 1'b1;
    base_w = mw_data.size(); base_rd = m_rd_cyc.size(); base_fs = n_fs; base_re = n_rerr;
    for (int i = 0; i < ROWB - 6; i++) drive(1'b1, 1'b0, 8'($urandom), ed);
    repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
    for (int i = 0; i < ROWB; i++) drive(1'b1, 1'b0, 8'($urandom), ed);
    repeat (3) drive(1'b0, 1'b0, 8'h00, ed);
    checks++;
    if (mw_data.size() != base_w || m_rd_cyc.size() != base_rd ||
        n_fs != base_fs || n_rerr != base_re) begin
      errors++;
      $display("FAIL post_reset_quiet: got words=%0d row_done=%0d fs=%0d rerr=%0d expected 0 0 0 0",
               mw_data.size() - base_w, m_rd_cyc.size() - base_rd, n_fs - base_fs, n_rerr - base_re);
    end
    row_lens = '{ROWB, ROWB, ROWB, ROWB};
    run_frame("after_reset", 1'b1, -1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_row();
    test_odd_row();
    test_overlong_row();
    test_excess_rows();
    test_truncated_row();
    test_back_to_back();
    test_enable();
    test_reset_midrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
